// File: rtl/riscv_pkg.sv
// Shared decode constants and state encoding for the memory stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscv_pkg;

    // Load/store funct3 encodings.
    // Bits [1:0] give the access size and bit 2 marks an unsigned load.
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACC1  = 3'd1,
        ST_ACC2  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } mau_state_e;

    // A half access must be 2-byte aligned and a word access 4-byte aligned.
    // Any funct3 size other than byte or half is treated as a word.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic mis;
        case (funct3[1:0])
            FUNCT3_LB[1:0]: mis = 1'b0;
            FUNCT3_LH[1:0]: mis = addr_lo[0];
            default:        mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Per-lane byte-lane steering: byte enables, store replication, load extraction and extension.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; this block only translates data.
// Ports:
//   funct3    : access size and sign
//   addr_lo   : low byte-address bits
//   wdata_in  : raw store data, with the significant bits at the LSBs
//   rdata_in  : raw memory word
//   be        : byte enables
//   wdata_rep : replicated store data
//   load_ext  : extended load value
module lsu_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata_in,
    input  logic [31:0] rdata_in,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext
);

    logic [31:0] shifted;

    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata_in;
        shifted   = rdata_in;
        load_ext  = rdata_in;
        case (funct3[1:0])
            FUNCT3_LB[1:0]: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata_in[7:0]}};
                shifted   = rdata_in >> {addr_lo, 3'b000};
                load_ext  = funct3[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            FUNCT3_LH[1:0]: begin
                // Bit 0 of the address is ignored, so the access is forced onto a half boundary.
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata_in[15:0]}};
                shifted   = rdata_in >> {addr_lo[1], 4'b0000};
                load_ext  = funct3[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_in;
                shifted   = rdata_in;
                load_ext  = rdata_in;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage for a dual-issue pair. Serialises lane 1 then lane 2 onto one single-port data memory.
// Latency: stalls the pipe for 1 + (one cycle per lane access, stretched by dmem_ready); then DONE for one cycle.
// Backpressure: StallM holds the upstream pipe; each dmem request is held stable until dmem_ready.
// Optional feature macro: MISALIGN_TRAP_EN (adds MisalignM; misaligned lanes skip the memory access).
// Ports:
//   clk, rst                  : clock and asynchronous active-high reset
//   flush, ValidM             : pipeline control for the pair held in EX/MEM
//   MemReadMx/MemWriteMx      : load/store flags for lane x
//   Funct3Mx, ALUResultMx     : access size/sign and byte address for lane x
//   WriteDataMx               : store data for lane x
//   ReadDataMx                : registered, extended load result for lane x
//   StallM                    : stall request to fetch..EX/MEM and the MEM/WB enables
//   dmem_*                    : request/response interface to the data memory
//   MisalignM                 : per-lane misalignment flags (only with MISALIGN_TRAP_EN)
module memory_access_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ValidM,
    input  logic              MemReadM1,
    input  logic              MemReadM2,
    input  logic              MemWriteM1,
    input  logic              MemWriteM2,
    input  logic [2:0]        Funct3M1,
    input  logic [2:0]        Funct3M2,
    input  logic [31:0]       ALUResultM1,
    input  logic [31:0]       ALUResultM2,
    input  logic [31:0]       WriteDataM1,
    input  logic [31:0]       WriteDataM2,
    output logic [31:0]       ReadDataM1,
    output logic [31:0]       ReadDataM2,
    output logic              StallM,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
`ifdef MISALIGN_TRAP_EN
    output logic [1:0]        MisalignM,
`endif
    input  logic              dmem_ready,
    input  logic [31:0]       dmem_rdata
);

    mau_state_e state_q, state_d;

    logic              op1, op2;
    logic              mis1, mis2;
    logic [ADDR_W-1:0] a1, a2;
    logic [3:0]        be1, be2;
    logic [31:0]       wrep1, wrep2;
    logic [31:0]       ext1, ext2;

    logic              issue1, issue2;
    logic              req_d, we_d;
    logic [ADDR_W-1:0] addr_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [31:0]       rd1_d, rd2_d;

    assign op1 = MemReadM1 | MemWriteM1;
    assign op2 = MemReadM2 | MemWriteM2;
    assign a1  = ALUResultM1[ADDR_W-1:0];
    assign a2  = ALUResultM2[ADDR_W-1:0];

`ifdef MISALIGN_TRAP_EN
    assign mis1 = is_misaligned(Funct3M1, ALUResultM1[1:0]);
    assign mis2 = is_misaligned(Funct3M2, ALUResultM2[1:0]);
`else
    // Without trapping, low address bits are simply dropped by the size rule.
    assign mis1 = 1'b0;
    assign mis2 = 1'b0;
`endif

    lsu_align u_align1 (
        .funct3    (Funct3M1),
        .addr_lo   (ALUResultM1[1:0]),
        .wdata_in  (WriteDataM1),
        .rdata_in  (dmem_rdata),
        .be        (be1),
        .wdata_rep (wrep1),
        .load_ext  (ext1)
    );

    lsu_align u_align2 (
        .funct3    (Funct3M2),
        .addr_lo   (ALUResultM2[1:0]),
        .wdata_in  (WriteDataM2),
        .rdata_in  (dmem_rdata),
        .be        (be2),
        .wdata_rep (wrep2),
        .load_ext  (ext2)
    );

    // The stall is raised in IDLE as soon as a memory pair shows up, so EX/MEM
    // holds the pair while the lane accesses run from the registered request.
    always_comb begin
        StallM = 1'b0;
        case (state_q)
            ST_ACC1, ST_ACC2, ST_DRAIN: StallM = 1'b1;
            ST_IDLE:                    StallM = ValidM && (op1 || op2) && !flush;
            default:                    StallM = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        issue1  = 1'b0;
        issue2  = 1'b0;
        req_d   = dmem_req;
        we_d    = dmem_we;
        addr_d  = dmem_addr;
        be_d    = dmem_be;
        wdata_d = dmem_wdata;
        rd1_d   = ReadDataM1;
        rd2_d   = ReadDataM2;

        case (state_q)
            ST_IDLE: begin
                if (ValidM && !flush) begin
                    if (op1) begin
                        state_d = ST_ACC1;
                        issue1  = 1'b1;
                    end else if (op2) begin
                        state_d = ST_ACC2;
                        issue2  = 1'b1;
                    end
                end
            end
            ST_ACC1: begin
                // A misaligned lane never went to memory, so its step ends at once.
                if (mis1 || dmem_ready) begin
                    req_d = 1'b0;
                    if (!flush) begin
                        if (mis1)
                            rd1_d = 32'h0;
                        else if (MemReadM1)
                            rd1_d = ext1;
                    end
                    if (flush) begin
                        state_d = ST_IDLE;
                    end else if (op2) begin
                        state_d = ST_ACC2;
                        issue2  = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_ACC2: begin
                if (mis2 || dmem_ready) begin
                    req_d = 1'b0;
                    if (!flush) begin
                        if (mis2)
                            rd2_d = 32'h0;
                        else if (MemReadM2)
                            rd2_d = ext2;
                    end
                    state_d = flush ? ST_IDLE : ST_DONE;
                end else if (flush) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            ST_DRAIN: begin
                // The request already in flight must still complete, since a store may commit.
                // Its read data is thrown away.
                if (dmem_ready || !dmem_req) begin
                    req_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                req_d   = 1'b0;
            end
        endcase

        if (issue1) begin
            req_d   = !mis1;
            we_d    = MemWriteM1;
            addr_d  = {a1[ADDR_W-1:2], 2'b00};
            be_d    = be1;
            wdata_d = MemWriteM1 ? wrep1 : 32'h0;
        end else if (issue2) begin
            req_d   = !mis2;
            we_d    = MemWriteM2;
            addr_d  = {a2[ADDR_W-1:2], 2'b00};
            be_d    = be2;
            wdata_d = MemWriteM2 ? wrep2 : 32'h0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
            ReadDataM1 <= 32'h0;
            ReadDataM2 <= 32'h0;
        end else begin
            state_q    <= state_d;
            dmem_req   <= req_d;
            dmem_we    <= we_d;
            dmem_addr  <= addr_d;
            dmem_be    <= be_d;
            dmem_wdata <= wdata_d;
            ReadDataM1 <= rd1_d;
            ReadDataM2 <= rd2_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic [1:0] mis_q;

    // The flags stay set through DONE so that writeback can see them, and are cleared on return to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mis_q <= 2'b00;
        end else if (state_d == ST_IDLE) begin
            mis_q <= 2'b00;
        end else begin
            if (state_q == ST_ACC1 && mis1 && !flush)
                mis_q[0] <= 1'b1;
            if (state_q == ST_ACC2 && mis2 && !flush)
                mis_q[1] <= 1'b1;
        end
    end

    assign MisalignM = mis_q;
`endif

endmodule

// File: tb/tb_memory_access_unit.sv
// Directed bench for memory_access_unit with a behavioural single-port memory that has a configurable latency.
// Latency: memory answers after 'lat' wait cycles per request.
// Backpressure: dmem_ready is withheld for the first 'lat' cycles of each request.
module tb_memory_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush, ValidM;
    logic        MemReadM1, MemReadM2, MemWriteM1, MemWriteM2;
    logic [2:0]  Funct3M1, Funct3M2;
    logic [31:0] ALUResultM1, ALUResultM2, WriteDataM1, WriteDataM2;
    logic [31:0] ReadDataM1, ReadDataM2;
    logic        StallM, dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
`ifdef MISALIGN_TRAP_EN
    logic [1:0]  MisalignM;
`endif

    logic [31:0] mem [0:255];
    int          lat, wait_cnt, nreq, checks, errors;

    memory_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ValidM(ValidM),
        .MemReadM1(MemReadM1), .MemReadM2(MemReadM2),
        .MemWriteM1(MemWriteM1), .MemWriteM2(MemWriteM2),
        .Funct3M1(Funct3M1), .Funct3M2(Funct3M2),
        .ALUResultM1(ALUResultM1), .ALUResultM2(ALUResultM2),
        .WriteDataM1(WriteDataM1), .WriteDataM2(WriteDataM2),
        .ReadDataM1(ReadDataM1), .ReadDataM2(ReadDataM2),
        .StallM(StallM), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
`ifdef MISALIGN_TRAP_EN
        .MisalignM(MisalignM),
`endif
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at the falling edge. It answers the request the DUT is presenting,
    // commits stores on the accepting cycle, and then settles 1 time unit.
    task automatic mem_drive();
        logic [31:0] w;
        logic [7:0]  idx;
        idx = dmem_addr[9:2];
        if (dmem_req) begin
            if (wait_cnt == lat) begin
                dmem_ready = 1'b1;
                dmem_rdata = dmem_we ? 32'h0 : mem[idx];
                if (dmem_we) begin
                    w = mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (dmem_be[b]) w[8*b +: 8] = dmem_wdata[8*b +: 8];
                    mem[idx] = w;
                end
                wait_cnt = 0;
                nreq++;
            end else begin
                dmem_ready = 1'b0;
                wait_cnt++;
            end
        end else begin
            dmem_ready = 1'b0;
            wait_cnt   = 0;
        end
        #1;
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    task automatic clr();
        ValidM = 0; flush = 0;
        MemReadM1 = 0; MemReadM2 = 0; MemWriteM1 = 0; MemWriteM2 = 0;
        Funct3M1 = 3'b000; Funct3M2 = 3'b000;
        ALUResultM1 = 0; ALUResultM2 = 0; WriteDataM1 = 0; WriteDataM2 = 0;
    endtask

    initial begin
        checks = 0; errors = 0; lat = 0; wait_cnt = 0; nreq = 0;
        dmem_ready = 0; dmem_rdata = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h40] = 32'hDEADBEEF;
        clr();
        rst = 1;
        @(negedge clk); @(negedge clk);
        chk("rst_rd1", ReadDataM1, 32'h0);
        chk("rst_rd2", ReadDataM2, 32'h0);
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_we", dmem_we, 1'b0);
        chk("rst_addr", dmem_addr, 32'h0);
        chk("rst_be", dmem_be, 4'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_stall", StallM, 1'b0);
        rst = 0;
        adv();

        // Lane 1 LW @0x100, memory with zero wait states.
        ValidM = 1; MemReadM1 = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h100; nreq = 0;
        mem_drive(); chk("t1_stall_idle", StallM, 1); chk("t1_req_idle", dmem_req, 0); adv();
        mem_drive(); chk("t1_stall_acc", StallM, 1); chk("t1_req_acc", dmem_req, 1);
        chk("t1_addr", dmem_addr, 32'h100); chk("t1_be", dmem_be, 4'hF); chk("t1_we", dmem_we, 0); adv();
        mem_drive(); chk("t1_stall_done", StallM, 0); chk("t1_rd1", ReadDataM1, 32'hDEADBEEF);
        chk("t1_req_done", dmem_req, 0); chk("t1_nreq", nreq, 1); clr(); adv();

        // Lane 1 SB 0xAB @0x103, then lane 2 LB @0x103 observes the store.
        ValidM = 1; MemWriteM1 = 1; Funct3M1 = 3'b000; ALUResultM1 = 32'h103; WriteDataM1 = 32'h000000AB;
        MemReadM2 = 1; Funct3M2 = 3'b000; ALUResultM2 = 32'h103;
        mem_drive(); chk("t2_stall_idle", StallM, 1); adv();
        mem_drive(); chk("t2_be1", dmem_be, 4'b1000); chk("t2_wdata", dmem_wdata, 32'hABABABAB);
        chk("t2_we1", dmem_we, 1); chk("t2_addr1", dmem_addr, 32'h100); adv();
        mem_drive(); chk("t2_req2", dmem_req, 1); chk("t2_we2", dmem_we, 0); chk("t2_be2", dmem_be, 4'b1000);
        chk("t2_stall_acc2", StallM, 1); adv();
        mem_drive(); chk("t2_stall_done", StallM, 0); chk("t2_rd2", ReadDataM2, 32'hFFFFFFAB);
        chk("t2_rd1_held", ReadDataM1, 32'hDEADBEEF); clr(); adv();

        // Lane-2-only LHU @0x102, three wait states.
        mem[8'h40] = 32'h80010000; lat = 3; nreq = 0;
        ValidM = 1; MemReadM2 = 1; Funct3M2 = 3'b101; ALUResultM2 = 32'h102;
        mem_drive(); chk("t3_stall_idle", StallM, 1); adv();
        for (int i = 0; i < 4; i++) begin
            mem_drive(); chk("t3_req", dmem_req, 1); chk("t3_addr", dmem_addr, 32'h100);
            chk("t3_be", dmem_be, 4'b1100); chk("t3_stall", StallM, 1); adv();
        end
        mem_drive(); chk("t3_stall_done", StallM, 0); chk("t3_rd2", ReadDataM2, 32'h00008001);
        chk("t3_nreq", nreq, 1); clr(); adv();

        // Lane 1 SW, flushed during its first access cycle; the store still commits and lane 2 never issues.
        lat = 2; nreq = 0;
        ValidM = 1; MemWriteM1 = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h204; WriteDataM1 = 32'h12345678;
        MemWriteM2 = 1; Funct3M2 = 3'b010; ALUResultM2 = 32'h208; WriteDataM2 = 32'hCAFEF00D;
        mem_drive(); adv();
        flush = 1;
        mem_drive(); chk("t4_req_acc1", dmem_req, 1); chk("t4_stall_acc1", StallM, 1); chk("t4_addr", dmem_addr, 32'h204);
        clr(); adv();
        mem_drive(); chk("t4_req_drain", dmem_req, 1); chk("t4_addr_drain", dmem_addr, 32'h204);
        chk("t4_we_drain", dmem_we, 1); chk("t4_stall_drain", StallM, 1); adv();
        mem_drive(); chk("t4_stall_drain2", StallM, 1); adv();
        mem_drive(); chk("t4_req_idle", dmem_req, 0); chk("t4_stall_idle", StallM, 0);
        chk("t4_commit", mem[8'h81], 32'h12345678); chk("t4_no_lane2", mem[8'h82], 32'h0); adv();
        mem_drive(); chk("t4_req_idle2", dmem_req, 0); chk("t4_nreq", nreq, 1);
        lat = 0; adv();

        // A valid pair with no memory ops passes straight through.
        ValidM = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h300;
        for (int i = 0; i < 2; i++) begin
            mem_drive(); chk("t5_stall", StallM, 0); chk("t5_req", dmem_req, 0);
            chk("t5_rd1", ReadDataM1, 32'hDEADBEEF); chk("t5_rd2", ReadDataM2, 32'h00008001); adv();
        end
        clr();

        // A flush while in IDLE suppresses the stall and the request.
        ValidM = 1; MemReadM1 = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h100; flush = 1;
        mem_drive(); chk("t6_stall", StallM, 0); clr(); adv();
        mem_drive(); chk("t6_req", dmem_req, 0); adv();

        // A flush in the same cycle as dmem_ready returns straight to IDLE. The next pair, LH @0x102, then runs normally.
        ValidM = 1; MemReadM1 = 1; Funct3M1 = 3'b001; ALUResultM1 = 32'h102;
        mem_drive(); adv();
        flush = 1; mem_drive(); chk("t7_req_acc", dmem_req, 1); adv();
        flush = 0; mem_drive(); chk("t7_stall_idle", StallM, 1); chk("t7_req_idle", dmem_req, 0); adv();
        mem_drive(); chk("t7_req2", dmem_req, 1); chk("t7_be", dmem_be, 4'b1100); adv();
        mem_drive(); chk("t7_stall_done", StallM, 0); chk("t7_rd1", ReadDataM1, 32'hFFFF8001); clr(); adv();

`ifdef MISALIGN_TRAP_EN
        // A misaligned LW issues no request and ends its step after one cycle.
        nreq = 0;
        ValidM = 1; MemReadM1 = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h101;
        mem_drive(); adv();
        mem_drive(); chk("t8_req", dmem_req, 0); chk("t8_mis_acc", MisalignM, 2'b00); adv();
        mem_drive(); chk("t8_stall_done", StallM, 0); chk("t8_mis", MisalignM, 2'b01);
        chk("t8_rd1", ReadDataM1, 32'h0); clr(); adv();
        mem_drive(); chk("t8_mis_clr", MisalignM, 2'b00); chk("t8_nreq", nreq, 0); adv();
`else
        // Without trapping, an LW @0x101 is forced to the word boundary and issued as a full word.
        ValidM = 1; MemReadM1 = 1; Funct3M1 = 3'b010; ALUResultM1 = 32'h101;
        mem_drive(); adv();
        mem_drive(); chk("t8_req", dmem_req, 1); chk("t8_addr", dmem_addr, 32'h100); chk("t8_be", dmem_be, 4'hF); adv();
        mem_drive(); chk("t8_rd1", ReadDataM1, 32'h80010000); clr(); adv();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
